// File: rtl/ls_multiple_seq.sv
// Load/store multiple sequencer: expands one lmw/stmw into single-word
// memory requests for GPRs rt..r31 at consecutive word addresses.
module ls_multiple_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [4:0]  rt,
  input  logic [31:0] ea,
  input  logic        flush,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [4:0]  reg_sel,
  output logic        wb_en,
  output logic        first_cycle,
  output logic        multiple_inc,
  output logic        busy,
  output logic        issue_stall,
  output logic        align_exc,
  output logic        done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [4:0]  r_reg, w_reg_nxt;
  logic        r_we, w_we_nxt;
  logic        r_first, w_first_nxt;
  logic        r_inc, w_inc_nxt;
  logic        r_align, w_align_nxt;
  logic        r_done, w_done_nxt;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_reg   <= '0;
      r_we    <= 1'b0;
      r_first <= 1'b0;
      r_inc   <= 1'b0;
      r_align <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_reg   <= w_reg_nxt;
      r_we    <= w_we_nxt;
      r_first <= w_first_nxt;
      r_inc   <= w_inc_nxt;
      r_align <= w_align_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output decode; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_reg_nxt   = r_reg;
    w_we_nxt    = r_we;
    w_first_nxt = r_first;
    w_inc_nxt   = r_inc;
    w_align_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_reg_nxt   = '0;
      w_we_nxt    = 1'b0;
      w_first_nxt = 1'b0;
      w_inc_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ea[1:0] == 2'b00) begin
              w_state_nxt = S_REQ;
              w_addr_nxt  = ea;
              w_reg_nxt   = rt;
              w_we_nxt    = is_store;
              w_first_nxt = 1'b1;
              w_inc_nxt   = 1'b0;
            end else begin
              w_align_nxt = 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (r_reg != 5'd31) begin
              w_addr_nxt  = r_addr + 32'd4;
              w_reg_nxt   = r_reg + 5'd1;
              w_first_nxt = 1'b0;
              w_inc_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_first_nxt = 1'b0;
              w_inc_nxt   = 1'b0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign mem_req      = (r_state == S_REQ);
  assign busy         = (r_state == S_REQ);
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign reg_sel      = r_reg;
  assign first_cycle  = r_first;
  assign multiple_inc = r_inc;
  assign align_exc    = r_align;
  assign done         = r_done;
  assign wb_en        = mem_req & mem_ack & ~r_we & ~flush;
  assign issue_stall  = start | busy;

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy));

endmodule

// File: tb/tb_ls_multiple_seq.sv
// Randomized self-checking bench for ls_multiple_seq against a word-list model.
module tb_ls_multiple_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [4:0]  rt = '0;
  logic [31:0] ea = '0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, wb_en, first_cycle, multiple_inc;
  logic        busy, issue_stall, align_exc, done;
  logic [31:0] mem_addr;
  logic [4:0]  reg_sel;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;

  ls_multiple_seq dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .rt(rt),
    .ea(ea), .flush(flush), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .reg_sel(reg_sel), .wb_en(wb_en),
    .first_cycle(first_cycle), .multiple_inc(multiple_inc), .busy(busy),
    .issue_stall(issue_stall), .align_exc(align_exc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // All outputs at their reset values (inputs start/flush/ack assumed low or irrelevant)
  task automatic chk_cleared(input string tag);
    chk({tag, ".req"},   32'(mem_req), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".we"},    32'(mem_we), 0);
    chk({tag, ".addr"},  mem_addr, 0);
    chk({tag, ".reg"},   32'(reg_sel), 0);
    chk({tag, ".first"}, 32'(first_cycle), 0);
    chk({tag, ".inc"},   32'(multiple_inc), 0);
    chk({tag, ".align"}, 32'(align_exc), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".wb"},    32'(wb_en), 0);
  endtask

  // mode: 0 = ack always, 1 = random ack, 2 = ack withheld in cycles 1-2
  // flush_at/reset_at: cycle (1-based after start) to abort in, 0 = never
  task automatic run_seq(input logic st, input logic [4:0] r, input logic [31:0] a,
                         input int mode, input int flush_at, input int reset_at);
    int unsigned cnt, idx, c;
    logic ack;
    bit ended;
    cnt = 32 - int'(r);
    idx = 0;
    @(negedge clk);
    start = 1'b1; is_store = st; rt = r; ea = a; mem_ack = 1'b0; flush = 1'b0;
    #1 chk("stall_on_start", 32'(issue_stall), 1);
    @(negedge clk);
    start = 1'b0; rt = 5'($urandom); ea = $urandom; is_store = 1'($urandom);
    if (a[1:0] != 2'b00) begin
      chk("align_exc", 32'(align_exc), 1);
      chk("align_req", 32'(mem_req), 0);
      chk("align_busy", 32'(busy), 0);
      @(negedge clk);
      chk("align_pulse_end", 32'(align_exc), 0);
      chk("align_req2", 32'(mem_req), 0);
      chk("align_busy2", 32'(busy), 0);
      return;
    end
    c = 1;
    ended = 0;
    while (!ended) begin
      chk("req",   32'(mem_req), 1);
      chk("busy",  32'(busy), 1);
      chk("addr",  mem_addr, a + 32'(4 * idx));
      chk("reg",   32'(reg_sel), 32'(r) + idx);
      chk("we",    32'(mem_we), 32'(st));
      chk("first", 32'(first_cycle), 32'(idx == 0));
      chk("inc",   32'(multiple_inc), 32'(idx != 0));
      chk("done_early", 32'(done), 0);
      chk("stall", 32'(issue_stall), 1);
      case (mode)
        0:       ack = 1'b1;
        2:       ack = (c >= 3);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      mem_ack = ack;
      if (c == flush_at) begin
        flush = 1'b1;
        #1 chk("wb_flush", 32'(wb_en), 0);
        @(negedge clk);
        flush = 1'b0; mem_ack = 1'b0;
        #1 chk_cleared("post_flush");
        @(negedge clk);
        chk("no_done_flush", 32'(done), 0);
        chk("req_flush2", 32'(mem_req), 0);
        ended = 1;
      end else if (c == reset_at) begin
        #1 reset = 1'b1;
        mem_ack = 1'b0;
        #1 chk_cleared("async_reset");
        chk("stall_reset", 32'(issue_stall), 0);
        @(negedge clk);
        reset = 1'b0;
        chk_cleared("post_reset");
        @(negedge clk);
        chk("req_reset2", 32'(mem_req), 0);
        ended = 1;
      end else begin
        #1 chk("wb_en", 32'(wb_en), 32'(ack & ~st));
        @(negedge clk);
        if (ack) idx++;
        if (idx == cnt) begin
          chk("done", 32'(done), 1);
          chk("busy_end", 32'(busy), 0);
          chk("req_end", 32'(mem_req), 0);
          chk("first_end", 32'(first_cycle), 0);
          chk("inc_end", 32'(multiple_inc), 0);
          mem_ack = 1'($urandom_range(0, 1));
          #1 chk("wb_idle", 32'(wb_en), 0);
          @(negedge clk);
          mem_ack = 1'b0;
          chk("done_pulse", 32'(done), 0);
          chk("req_idle", 32'(mem_req), 0);
          ended = 1;
        end
        c++;
        if (!ended && c > 400) begin
          chk("timeout", 32'(c), 0);
          ended = 1;
        end
      end
    end
  endtask

  initial begin
    logic [4:0]  r;
    logic [31:0] a;
    int          fa;
    #2 chk_cleared("in_reset");
    chk("stall_in_reset", 32'(issue_stall), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_cleared("after_reset");

    run_seq(1'b0, 5'd29, 32'h0000_0100, 0, 0, 0);
    run_seq(1'b1, 5'd31, 32'h0000_0040, 0, 0, 0);
    run_seq(1'b0, 5'd30, 32'h0000_0200, 2, 0, 0);
    run_seq(1'b0, 5'd0,  32'h0000_0102, 0, 0, 0);
    run_seq(1'b1, 5'd28, 32'hFFFF_FFF8, 0, 0, 0);
    run_seq(1'b0, 5'd20, 32'h0000_1000, 0, 3, 0);
    run_seq(1'b0, 5'd20, 32'h0000_1000, 0, 0, 3);
    run_seq(1'b1, 5'd0,  32'h0000_8000, 1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      r = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(24, 31));
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_seq(1'($urandom), r, a, int'($urandom_range(0, 1)), fa, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ls_multiple_seq.md
# ls_multiple_seq

Sequencer for PowerPC load/store multiple (`lmw`/`stmw`) in the load/store pipeline. It takes one decoded multiple-word instruction and expands it into a stream of single-word memory requests, one per GPR from `rt` through r31, at consecutive word addresses. It drives the per-word `first_cycle`/`multiple_inc` qualifiers and the GPR read/write selects, and holds issue until the sequence finishes. It sits between decode (`Load_store_ctrl_if`) and the data-memory request port.

## Interface
- No parameters. Word size is fixed at 32 bit and register count at 32.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: a valid `lmw`/`stmw` is issued.
- `is_store`  in  1  sampled with `start`: 1 = `stmw`, 0 = `lmw`.
- `rt`  in  5  sampled with `start`: first register.
- `ea`  in  32  sampled with `start`: effective base address.
- `flush`  in  1  pipeline flush; abort sequence.
- `mem_ack`  in  1  memory accepts current request this cycle.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  request is a store.
- `mem_addr`  out  32  word address of current request.
- `reg_sel`  out  5  GPR of current word: read select for stores, write-back index for loads.
- `wb_en`  out  1  load word accepted; write `reg_sel` (same cycle as `mem_ack`).
- `first_cycle`  out  1  current request is the first word.
- `multiple_inc`  out  1  current request is not the first word.
- `busy`  out  1  sequence in progress.
- `issue_stall`  out  1  combinational `start | busy`; freezes frontend.
- `align_exc`  out  1  one-cycle pulse: unaligned `ea` at `start`.
- `done`  out  1  one-cycle pulse: last word accepted.

## Operation
- States: IDLE, REQ.
- IDLE with `start` and `ea[1:0]==0`:
  - latch `mem_addr=ea`, `reg_sel=rt`, `mem_we=is_store`;
  - set `first_cycle`;
  - enter REQ.
- IDLE with `start` and `ea[1:0]!=0`:
  - pulse `align_exc` next cycle;
  - stay IDLE; no request is issued.
- REQ: `mem_req=1`. Address, register and write-enable are held stable until `mem_ack`.
- REQ with `mem_ack` and `reg_sel!=31`:
  - `mem_addr += 4`, `reg_sel += 1`;
  - clear `first_cycle`, set `multiple_inc`;
  - stay in REQ.
- REQ with `mem_ack` and `reg_sel==31`:
  - go to IDLE; pulse `done` next cycle;
  - clear `first_cycle` and `multiple_inc`.
- Transfer count is `32-rt`. `rt=31` gives a single word with `first_cycle=1` and `multiple_inc=0`.
- `wb_en = mem_req & mem_ack & ~mem_we` (combinational).
- Address arithmetic is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0. `reg_sel` never wraps because the sequence ends at 31.
- `flush` in any state:
  - next state IDLE; all outputs except `issue_stall` go to reset values;
  - no `done`. `wb_en` is suppressed in the flush cycle.
- `flush` and `start` in the same cycle: `flush` wins; no sequence starts.
- `start` while `busy` is a protocol violation. It is ignored, and a simulation-only assertion flags it.
- `mem_ack` while `mem_req=0` is ignored.

## Timing
- Reset values: `mem_req`, `mem_we`, `busy`, `first_cycle`, `multiple_inc`, `align_exc`, `done` = 0; `mem_addr` = 0; `reg_sel` = 0. `wb_en` and `issue_stall` are 0 while reset is asserted with `start` low.
- Reset mid-sequence: immediate return to IDLE, asynchronous. No further requests.
- `start` in cycle 0 → `mem_req` and `busy` high in cycle 1 (registered, one cycle latency).
- With `mem_ack` held high, one word per cycle: N words occupy cycles 1..N, `done` is in cycle N+1, and `busy` falls in cycle N+1.
- `align_exc` is in cycle 1; `busy` stays 0.
- Outputs other than `wb_en` and `issue_stall` are registered.

## Test plan
- `lmw`, `rt=29`, `ea=0x100`, `mem_ack=1` → requests at 0x100/0x104/0x108 with `reg_sel` 29/30/31 in cycles 1–3, `first_cycle` only in cycle 1, `wb_en` in cycles 1–3, `done` in cycle 4.
- `stmw`, `rt=31`, `ea=0x40` → one request, `mem_we=1`, `first_cycle=1`, `multiple_inc=0`, no `wb_en`, `done` in cycle 2.
- `lmw`, `rt=30`, `ea=0x200`, `mem_ack` low in cycles 1–2 → `mem_addr` holds 0x200 and `reg_sel` holds 30 until the ack in cycle 3; 0x204 is issued in cycle 4; `done` in cycle 5.
- `start` with `ea=0x102` → `align_exc` in cycle 1; `mem_req` never asserts; `busy` stays 0.
- `stmw`, `rt=28`, `ea=0xFFFFFFF8` → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- `lmw`, `rt=20`; `flush` in cycle 3 → `mem_req`, `busy` and `wb_en` are 0 from cycle 4 with no `done`. Repeat with `reset` asserted mid-sequence → all outputs return to reset values immediately.
